counter_unit: RTL and testbench
===============================

COUNTER_UNIT -- requirements
Module: counter_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter PRESET_DEFAULT, default 100: count value loaded at reset.
REQ-003 SHALL have parameter PRESCALE_W, default 4: prescaler width, used only under COUNTER_PRESCALE_EN.
REQ-004 SHALL have port: clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port: reset_btn  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port: start  in  1  pulse; begin counting.
REQ-007 SHALL have port: stop  in  1  pulse; abort to IDLE.
REQ-008 SHALL have port: enable  in  1  count gate while running.
REQ-009 SHALL have port: mode  in  2  00 up-wrap, 01 down-wrap, 10 up-oneshot, 11 down-oneshot.
REQ-010 SHALL have port: load  in  1  synchronous load strobe.
REQ-011 SHALL have port: load_value  in  WIDTH  value for load.
REQ-012 SHALL have port: clear_flags  in  1  clears sticky flags.
REQ-013 SHALL have ports: count  out  WIDTH  registered count; overflow  out  1  sticky up-wrap flag; underflow  out  1  sticky down-wrap flag; zero  out  1  count==0, combinational from count; done  out  1  high in DONE; busy  out  1  high in RUN or PAUSE.

Function
REQ-014 SHALL implement FSM IDLE, RUN, PAUSE, DONE; done and busy decoded from state register.
REQ-015 SHALL transition IDLE->RUN on start; RUN->PAUSE when enable=0; PAUSE->RUN when enable=1; RUN->DONE on one-shot terminal; DONE->RUN on start; any state->IDLE on stop.
REQ-016 SHALL give stop priority over start when both are asserted in the same cycle.
REQ-017 SHALL step count by exactly 1 per tick only in RUN with enable=1; no step in the cycle of the IDLE->RUN transition.
REQ-018 SHALL wrap up-wrap mode from 2^WIDTH-1 to 0 and set overflow; down-wrap mode from 0 to 2^WIDTH-1 and set underflow.
REQ-019 SHALL, in one-shot modes, stop at terminal (2^WIDTH-1 up, 0 down), hold count, enter DONE next cycle, set no flag.
REQ-020 SHALL, if start occurs in RUN, ignore it; if in DONE, resume counting from the held count (terminal, so a one-shot re-enters DONE after one tick).
REQ-021 SHALL apply load in any state, count<=load_value next cycle, no state change; load has priority over stepping; a load coinciding with a terminal/wrap step suppresses flag and DONE transition.
REQ-022 SHALL hold mode changes mid-run to take effect on the next step.
REQ-023 SHALL clear overflow/underflow on clear_flags; a wrap in the same cycle wins (flag set).

Reset
REQ-024 SHALL on reset_btn=1 at a clk edge set count=PRESET_DEFAULT, state=IDLE, overflow=0, underflow=0, done=0, busy=0, prescaler=0; reset overrides all inputs, including mid-run.

Configuration
REQ-025 SHALL, with COUNTER_PRESCALE_EN defined, add input prescale [PRESCALE_W-1:0]; a tick occurs once per prescale+1 enabled RUN cycles; prescaler cleared on reset, stop, load and on leaving RUN.
REQ-026 SHALL, without COUNTER_PRESCALE_EN, omit the prescale port and prescaler; tick every enabled RUN cycle.

Structure
REQ-027 SHALL place mode encoding enum and FSM state enum in package counter_pkg.
REQ-028 SHALL implement the prescaler as sub-module counter_prescaler (clk, reset_btn, clr, run, prescale -> tick), instantiated only under COUNTER_PRESCALE_EN.

Verification (WIDTH=8, PRESET_DEFAULT=100)
REQ-029 SHALL cover: reset -> count=100, zero=0, done=0, busy=0, flags=0.
REQ-030 SHALL cover: load 253, mode 00, start, enable=1 -> 254, 255, 0 (overflow=1, zero=1), 1; clear_flags -> overflow=0.
REQ-031 SHALL cover: load 2, mode 11, start -> 1, 0, DONE, done=1, count held 0, underflow=0.
REQ-032 SHALL cover: mode 00 at 255, load 7 same cycle as wrap -> count=7, overflow=0.
REQ-033 SHALL cover: RUN, enable=0 for 3 cycles -> PAUSE, count frozen; stop+start same cycle -> IDLE.
REQ-034 SHALL cover, with COUNTER_PRESCALE_EN and prescale=3: count steps every 4th enabled cycle; reset mid-run -> count=100, IDLE.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg -- shared types for the counter_unit slice.
//   mode_e  : counting mode encoding as seen on the 'mode' port.
//   state_e : control FSM states (IDLE, RUN, PAUSE, DONE).
//   mode_is_up / mode_is_oneshot : small decode helpers for mode_e.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP      = 2'b00,
    MODE_DOWN_WRAP    = 2'b01,
    MODE_UP_ONESHOT   = 2'b10,
    MODE_DOWN_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // True for the two counting-up modes.
  function automatic logic mode_is_up(input mode_e m);
    return (m == MODE_UP_WRAP) || (m == MODE_UP_ONESHOT);
  endfunction

  // True for the two modes that stop at the terminal value.
  function automatic logic mode_is_oneshot(input mode_e m);
    return (m == MODE_UP_ONESHOT) || (m == MODE_DOWN_ONESHOT);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler -- divides enabled RUN cycles down to count ticks.
// Used by counter_unit only when COUNTER_PRESCALE_EN is defined.
// Ports:
//   clk       in   clock, rising edge
//   reset_btn in   synchronous active-high reset
//   clr       in   synchronous clear of the divider
//   run       in   an enabled RUN cycle (advances the divider)
//   prescale  in   divide ratio minus one
//   tick      out  high on the run cycle that completes a period
module counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_btn,
  input  logic                  clr,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PS_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  // Tick on the (prescale+1)-th run cycle; the divider restarts from zero.
  assign tick = run && (cnt_q == prescale);

  // Next divider value: clear beats advance, tick restarts the period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + PS_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_btn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_unit.sv
// counter_unit -- up/down wrap or one-shot counter with IDLE/RUN/PAUSE/DONE
// control, synchronous load and sticky wrap flags.
// Optional feature macro: COUNTER_PRESCALE_EN adds the 'prescale' input and
// a counter_prescaler so the count steps once per prescale+1 enabled cycles.
// Ports:
//   clk         in   clock, rising edge
//   reset_btn   in   synchronous active-high reset
//   start       in   begin / resume counting
//   stop        in   abort to IDLE (beats start)
//   enable      in   count gate while running (low -> PAUSE)
//   mode[1:0]   in   00 up-wrap, 01 down-wrap, 10 up-oneshot, 11 down-oneshot
//   load        in   load strobe, count <= load_value next cycle
//   load_value  in   value for load
//   clear_flags in   clears overflow/underflow
//   prescale    in   (COUNTER_PRESCALE_EN only) tick divide ratio minus one
//   count       out  registered count
//   overflow    out  sticky up-wrap flag
//   underflow   out  sticky down-wrap flag
//   zero        out  count == 0
//   done        out  FSM in DONE
//   busy        out  FSM in RUN or PAUSE
module counter_unit
  import counter_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESET_DEFAULT = 100,
  parameter int PRESCALE_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset_btn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  clear_flags,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  zero,
  output logic                  done,
  output logic                  busy
);

  if ((WIDTH < 2) || (WIDTH > 32) || (PRESCALE_W < 1)) begin : g_bad_params
    $error("counter_unit: parameter out of legal range");
  end

  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] PRESET_VAL = WIDTH'(PRESET_DEFAULT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  mode_e mode_s;
  logic  up_s;
  logic  oneshot_s;
  logic  run_s;
  logic  tick_s;
  logic  step_s;
  logic  at_term_s;
  logic  wrap_s;
  logic  finish_s;

  // Mode is sampled live, so a mid-run change applies to the next step.
  assign mode_s    = mode_e'(mode);
  assign up_s      = mode_is_up(mode_s);
  assign oneshot_s = mode_is_oneshot(mode_s);
  assign run_s     = (state_q == ST_RUN) && enable;
  // stop aborts the cycle: no step, no flag, no DONE.
  assign step_s    = run_s && tick_s && !stop;
  assign at_term_s = up_s ? (count_q == MAX_VAL) : (count_q == ZERO_VAL);
  // A concurrent load replaces the step, so it also cancels flag and DONE.
  assign wrap_s    = step_s && at_term_s && !oneshot_s && !load;
  assign finish_s  = step_s && at_term_s && oneshot_s && !load;

`ifdef COUNTER_PRESCALE_EN
  logic pre_clr_s;

  // Divider restarts whenever the count is disturbed or RUN is left.
  assign pre_clr_s = stop || load || (state_q != ST_RUN);

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk       (clk),
    .reset_btn (reset_btn),
    .clr       (pre_clr_s),
    .run       (run_s),
    .prescale  (prescale),
    .tick      (tick_s)
  );
`else
  assign tick_s = 1'b1;
`endif

  // Next-state, next-count and next-flag computation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;

    if (load) begin
      count_d = load_value;
    end else if (step_s && !(oneshot_s && at_term_s)) begin
      count_d = up_s ? (count_q + ONE) : (count_q - ONE);
    end else begin
      count_d = count_q;
    end

    // A wrap in the same cycle as clear_flags leaves the flag set.
    overflow_d  = (wrap_s && up_s)  ? 1'b1 : (clear_flags ? 1'b0 : overflow_q);
    underflow_d = (wrap_s && !up_s) ? 1'b1 : (clear_flags ? 1'b0 : underflow_q);

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = start ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (!enable) begin
            state_d = ST_PAUSE;
          end else if (finish_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          state_d = enable ? ST_RUN : ST_PAUSE;
        end
        ST_DONE: begin
          state_d = start ? ST_RUN : ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // All architectural state, synchronous reset overriding every input.
  always_ff @(posedge clk) begin
    if (reset_btn) begin
      state_q     <= ST_IDLE;
      count_q     <= PRESET_VAL;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign zero      = (count_q == ZERO_VAL);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_counter_unit.sv
// tb_counter_unit -- self-checking bench for counter_unit (WIDTH=8,
// PRESET_DEFAULT=100). Directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the counter.
// Define COUNTER_PRESCALE_EN to also exercise the prescaler.
module tb_counter_unit;

  localparam int W      = 8;
  localparam int PRESET = 100;
  localparam int MODV   = 256;
  localparam int MAXV   = 255;
  localparam int PSMOD  = 16;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic         clk;
  logic         reset_btn;
  logic         start;
  logic         stop;
  logic         enable;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_value;
  logic         clear_flags;
  logic [3:0]   prescale;
  logic [W-1:0] count;
  logic         overflow;
  logic         underflow;
  logic         zero;
  logic         done;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_cnt;
  int m_st;
  int m_ov;
  int m_un;
  int m_pre;

  counter_unit #(
    .WIDTH          (W),
    .PRESET_DEFAULT (PRESET),
    .PRESCALE_W     (4)
  ) dut (
    .clk         (clk),
    .reset_btn   (reset_btn),
    .start       (start),
    .stop        (stop),
    .enable      (enable),
    .mode        (mode),
    .load        (load),
    .load_value  (load_value),
    .clear_flags (clear_flags),
`ifdef COUNTER_PRESCALE_EN
    .prescale    (prescale),
`endif
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .zero        (zero),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    int  ps;
    bit  up, one, run_c, tick_c, stepping, at_term, wrap;
    int  n_cnt, n_st;
    if (reset_btn) begin
      m_cnt = PRESET; m_st = S_IDLE; m_ov = 0; m_un = 0; m_pre = 0;
      return;
    end
    ps       = int'(prescale);
    up       = (mode == 2'd0) || (mode == 2'd2);
    one      = (mode >= 2'd2);
    run_c    = (m_st == S_RUN) && enable;
    tick_c   = run_c && (m_pre == ps);
    stepping = tick_c && !stop;
    at_term  = up ? (m_cnt == MAXV) : (m_cnt == 0);
    wrap     = stepping && !one && at_term && !load;

    n_cnt = m_cnt;
    if (load) n_cnt = int'(load_value);
    else if (stepping && !(one && at_term)) n_cnt = (m_cnt + (up ? 1 : -1) + MODV) % MODV;

    if (clear_flags) begin m_ov = 0; m_un = 0; end
    if (wrap && up) m_ov = 1;
    if (wrap && !up) m_un = 1;

    n_st = m_st;
    if (stop) n_st = S_IDLE;
    else if (m_st == S_IDLE && start) n_st = S_RUN;
    else if (m_st == S_DONE && start) n_st = S_RUN;
    else if (m_st == S_PAUSE && enable) n_st = S_RUN;
    else if (m_st == S_RUN && !enable) n_st = S_PAUSE;
    else if (m_st == S_RUN && stepping && one && at_term && !load) n_st = S_DONE;

    if (stop || load || m_st != S_RUN) m_pre = 0;
    else if (run_c) m_pre = (m_pre == ps) ? 0 : (m_pre + 1) % PSMOD;

    m_cnt = n_cnt;
    m_st  = n_st;
  endtask

  task automatic compare_all();
    check_eq("count",     32'(count),     32'(m_cnt));
    check_eq("overflow",  32'(overflow),  32'(m_ov));
    check_eq("underflow", 32'(underflow), 32'(m_un));
    check_eq("zero",      32'(zero),      32'(m_cnt == 0));
    check_eq("done",      32'(done),      32'(m_st == S_DONE));
    check_eq("busy",      32'(busy),      32'((m_st == S_RUN) || (m_st == S_PAUSE)));
  endtask

  task automatic step_cycle(input logic r, input logic s, input logic p, input logic e,
                            input logic [1:0] m, input logic l, input logic [7:0] lv,
                            input logic c);
    @(negedge clk);
    reset_btn = r; start = s; stop = p; enable = e;
    mode = m; load = l; load_value = lv; clear_flags = c;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    logic [1:0] md;
    logic       r, s, p, e, l, c;
    logic [7:0] lv;

    reset_btn = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0; mode = 2'd0;
    load = 1'b0; load_value = 8'd0; clear_flags = 1'b0; prescale = 4'd0;
    m_cnt = 0; m_st = S_IDLE; m_ov = 0; m_un = 0; m_pre = 0;

    // Reset state
    step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("rst_count", 32'(count), 32'd100);
    check_eq("rst_zero",  32'(zero),  32'd0);
    check_eq("rst_done",  32'(done),  32'd0);
    check_eq("rst_busy",  32'(busy),  32'd0);
    check_eq("rst_flags", 32'({overflow, underflow}), 32'd0);

    // Up-wrap through 255 -> 0 with overflow, then clear_flags
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd253, 1'b0);
    step_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("wrap_start_nostep", 32'(count), 32'd253);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("wrap_254", 32'(count), 32'd254);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("wrap_255", 32'(count), 32'd255);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("wrap_0", 32'(count), 32'd0);
    check_eq("wrap_ovf", 32'(overflow), 32'd1);
    check_eq("wrap_zero", 32'(zero), 32'd1);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("wrap_1", 32'(count), 32'd1);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b1);
    check_eq("ovf_cleared", 32'(overflow), 32'd0);

    // Down one-shot from 2 to DONE
    step_cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 8'd0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 8'd2, 1'b0);
    step_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 8'd0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 8'd0, 1'b0);
    check_eq("os_1", 32'(count), 32'd1);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 8'd0, 1'b0);
    check_eq("os_0", 32'(count), 32'd0);
    check_eq("os_not_done_yet", 32'(done), 32'd0);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 8'd0, 1'b0);
    check_eq("os_done", 32'(done), 32'd1);
    check_eq("os_held", 32'(count), 32'd0);
    check_eq("os_no_unf", 32'(underflow), 32'd0);
    step_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 8'd0, 1'b0);
    check_eq("os_resume_busy", 32'(busy), 32'd1);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 8'd0, 1'b0);
    check_eq("os_redone", 32'(done), 32'd1);

    // Load coinciding with a wrap step
    step_cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'd254, 1'b0);
    step_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("ldwrap_255", 32'(count), 32'd255);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'd7, 1'b0);
    check_eq("ldwrap_7", 32'(count), 32'd7);
    check_eq("ldwrap_noovf", 32'(overflow), 32'd0);

    // Pause for three cycles, resume, then stop+start together
    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
      check_eq("pause_frozen", 32'(count), 32'd7);
      check_eq("pause_busy", 32'(busy), 32'd1);
    end
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("unpause_nostep", 32'(count), 32'd7);
    step_cycle(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("stop_wins_busy", 32'(busy), 32'd0);
    check_eq("stop_wins_count", 32'(count), 32'd7);

`ifdef COUNTER_PRESCALE_EN
    // Prescale 3: step on every 4th enabled cycle; reset mid-run
    prescale = 4'd3;
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'd10, 1'b0);
    step_cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
      check_eq("ps_count", 32'(count), 32'(10 + i / 4));
    end
    step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0);
    check_eq("ps_rst_count", 32'(count), 32'd100);
    check_eq("ps_rst_busy", 32'(busy), 32'd0);
`endif

    // Randomized traffic
    md = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 29) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) md = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       lv = 8'd0;
        1:       lv = 8'd255;
        2:       lv = 8'd253;
        default: lv = 8'($urandom);
      endcase
      c = ($urandom_range(0, 14) == 0);
`ifdef COUNTER_PRESCALE_EN
      if ($urandom_range(0, 49) == 0) prescale = 4'($urandom_range(0, 3));
`endif
      step_cycle(r, s, p, e, md, l, lv, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
